rom_port_arbiter: RTL
=====================

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data and byte-address width, matching the ROM port width.
REQ-002 SHALL have parameter N_REQ, default 2, legal range 2..4, meaning the number of requesters sharing one ROM read port.
REQ-003 SHALL have parameter IDW, default 2, meaning requester-ID width; IDW SHALL be at least clog2(N_REQ).
REQ-004 SHALL have port clk, input, 1 bit: single clock; ROM port and arbiter use the same clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid, input, N_REQ bits: per-requester read request.
REQ-007 SHALL have port req_addr, input, N_REQ*WIDTH bits: per-requester byte address, packed with requester i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready, output, N_REQ bits: per-requester grant; at most one bit set.
REQ-009 SHALL have port rsp_valid, output, 1 bit: read data available.
REQ-010 SHALL have port rsp_id, output, IDW bits: index of the requester that owns rsp_data.
REQ-011 SHALL have port rsp_data, output, WIDTH bits: read data, driven directly from rom_rd.
REQ-012 SHALL have port rsp_ready, input, 1 bit: response consumer accepts.
REQ-013 SHALL have port rom_en, output, 1 bit: ROM port read enable.
REQ-014 SHALL have port rom_addr, output, WIDTH bits: ROM byte address; the ROM indexes words with addr[WIDTH-1:2].
REQ-015 SHALL have port rom_rd, input, WIDTH bits: registered ROM read data; it holds its value while rom_en=0.

Function
REQ-016 SHALL define request fire as req_valid[i] & req_ready[i], and response accept as rsp_valid & rsp_ready.
REQ-017 SHALL use FSM states IDLE (no response pending) and PEND (response pending).
REQ-018 SHALL allow a grant only when can_issue is true, where can_issue = (state==IDLE) | (rsp_valid & rsp_ready).
REQ-019 SHALL compute req_ready combinationally from req_valid, the priority pointer and can_issue; req_ready SHALL be one-hot or zero, and SHALL be zero if no requester is valid.
REQ-020 SHALL select by round-robin: the search starts at ptr, and after a fire by requester g, ptr becomes (g+1) mod N_REQ.
REQ-021 SHALL drive, on fire: rom_en=1 and rom_addr=req_addr of the granted requester, unmodified, in the same cycle.
REQ-022 SHALL drive rom_en=0 whenever there is no fire; rom_addr is don't-care but SHALL be driven to 0.
REQ-023 SHALL have a latency of 1: data for a fire in cycle t appears with rsp_valid=1 in cycle t+1, and rsp_id SHALL be registered with the granted index.
REQ-024 SHALL follow these transitions: IDLE to PEND on fire; PEND to PEND on accept with a new fire; PEND to IDLE on accept without fire; PEND holds when there is no accept.
REQ-025 SHALL hold rsp_valid, rsp_id and rsp_data stable while rsp_valid=1 and rsp_ready=0; this relies on the ROM holding rom_rd while rom_en=0.
REQ-026 SHALL achieve throughput of 1 read per cycle when rsp_ready is held at 1.
REQ-027 SHALL let rsp_ready while in IDLE have no effect.

Reset
REQ-028 SHALL, on rst=1, asynchronously set state=IDLE, rsp_valid=0, rsp_id=0 and ptr=0; req_ready=0 and rom_en=0 SHALL hold while rst=1.
REQ-029 SHALL discard a response pending at reset: it is never presented, and the first grant after reset favours requester 0.

Configuration
REQ-030 SHALL, with ROM_ARB_LOCK_EN defined, add input req_lock (N_REQ bits) to the interface.
REQ-031 SHALL, with ROM_ARB_LOCK_EN defined, not advance ptr on a fire by g if req_lock[g]=1, so that g keeps top priority for burst fetch.
REQ-032 SHALL, with ROM_ARB_LOCK_EN defined, block other requesters while g holds both req_valid[g] and req_lock[g].
REQ-033 SHALL, with ROM_ARB_LOCK_EN defined, resume normal rotation from g+1 at g's next fire with req_lock[g]=0.
REQ-034 SHALL, with ROM_ARB_LOCK_EN defined, release the lock if the locked requester drops req_valid, with rotation resuming from ptr unchanged.
REQ-035 SHALL, without ROM_ARB_LOCK_EN, omit the req_lock port and operate as pure round-robin.

Structure
REQ-036 SHALL place in package rom_arb_pkg: N_REQ_MAX=4, the state enum type (IDLE, PEND), and the requester-ID typedef.
REQ-037 SHALL implement the rotating-priority one-hot selector as sub-module rr_select (inputs: request vector, pointer; output: one-hot grant plus index).

Verification
REQ-038 SHALL verify single request: rsp_ready=1, req_valid=2'b01, addr=0x10 -> rom_en=1 with rom_addr=0x10 in the same cycle, next cycle rsp_valid=1, rsp_id=0, rsp_data=rom[4].
REQ-039 SHALL verify contention: both requesters valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_valid=1 every cycle after the first.
REQ-040 SHALL verify backpressure: rsp_ready=0 for 3 cycles with a response pending -> req_ready=0, rom_en=0, rsp_data/rsp_id stable; on rsp_ready=1, a new grant fires in the same cycle.
REQ-041 SHALL verify N_REQ=4 wrap: after a grant to 3, with requesters 1 and 3 valid -> next grant goes to 1.
REQ-042 SHALL verify mid-operation reset: rst asserted while in PEND -> rsp_valid=0 immediately; after release, with requesters 0 and 1 both valid, requester 0 is granted first.
REQ-043 SHALL verify lock (ROM_ARB_LOCK_EN defined): requester 1 locked for 4 fires with requester 0 valid -> 4 consecutive grants to 1, then after lock=0 the next grant goes to 0.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM port arbiter: requester limit, FSM state, requester ID.
package rom_arb_pkg;

    localparam int N_REQ_MAX = 4;

    typedef enum logic {
        IDLE,
        PEND
    } arb_state_t;

    typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;

endpackage

// File: rtl/rr_select.sv
// Rotating-priority one-hot selector: first set request at or after ptr wins.
// Purely combinational, zero latency; no flow control of its own.
// Grant is zero when no request is set.
module rr_select
    import rom_arb_pkg::*;
#(
    parameter int N = 2
)(
    input  logic [N-1:0] req,
    input  req_id_t      ptr,
    output logic [N-1:0] gnt,
    output req_id_t      gnt_idx,
    output logic         gnt_any
);

    localparam logic [2:0] N_EXT = 3'(N);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    req_id_t        off;
    logic [2:0]     sum;

    always_comb begin
        // Rotate so that bit 0 is the requester at ptr, then find the first set bit.
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: N];
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                off = req_id_t'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        gnt_idx = sum[1:0];
        gnt_any = |req;
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = gnt_any && (gnt_idx == req_id_t'(i));
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin sharing of one registered ROM read port; ROM_ARB_LOCK_EN adds req_lock burst hold.
// Latency 1: a grant in cycle t returns rsp_valid/rsp_id/rsp_data in cycle t+1.
// Backpressure: no grant while a response is pending and not accepted; outputs hold stable.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_REQ = 2,
    parameter int IDW   = 2
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
`ifdef ROM_ARB_LOCK_EN
    input  logic [N_REQ-1:0]       req_lock,
`endif
    input  logic [N_REQ*WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    input  logic                   rsp_ready,
    output logic                   rom_en,
    output logic [WIDTH-1:0]       rom_addr,
    input  logic [WIDTH-1:0]       rom_rd
);

    arb_state_t       state;
    req_id_t          ptr;
    req_id_t          ptr_nxt;
    logic [N_REQ-1:0] sel_gnt;
    req_id_t          sel_idx;
    logic             sel_any;
    logic             can_issue;
    logic             fire;
    logic             hold_ptr;

    rr_select #(.N(N_REQ)) u_sel (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (sel_gnt),
        .gnt_idx (sel_idx),
        .gnt_any (sel_any)
    );

    // rom_rd only changes after a fire, so it can feed rsp_data directly.
    assign rsp_data = rom_rd;

    always_comb begin
        can_issue = ((state == IDLE) || (rsp_valid && rsp_ready)) && !rst;
        req_ready = can_issue ? sel_gnt : '0;
        fire      = can_issue && sel_any;
        rom_en    = fire;
        rom_addr  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (fire && sel_gnt[i]) begin
                rom_addr = req_addr[i*WIDTH +: WIDTH];
            end
        end
        ptr_nxt = (sel_idx == req_id_t'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
`ifdef ROM_ARB_LOCK_EN
        // A locked fire keeps ptr on the winner, so it stays first in the search.
        hold_ptr = |(req_lock & sel_gnt);
`else
        hold_ptr = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else begin
            if (fire) begin
                state     <= PEND;
                rsp_valid <= 1'b1;
                rsp_id    <= IDW'(sel_idx);
                if (!hold_ptr) begin
                    ptr <= ptr_nxt;
                end
            end else if (rsp_valid && rsp_ready) begin
                state     <= IDLE;
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
